cmd_stream_loader: RTL and testbench

Parametrised successor to the TRS-80 `/CMD` download loader. Parses a `/CMD` record stream from the HPS ioctl port, then writes load-record payloads into system RAM through a ready/valid memory handshake. Supports a relocatable base address, a configurable address width, skipping of non-load records, and end-of-load status reporting. Sits between `hps_io` and the RAM arbiter.

---
 rtl/cmd_loader_pkg.sv | 47 ++++
 rtl/cmd_mem_port.sv | 79 +++++++
 rtl/cmd_stream_loader.sv | 196 +++++++++++++++++++
 tb/tb_cmd_stream_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_loader_pkg.sv
// Shared types and constants for the /CMD stream loader: parser states,
// record type bytes, status codes and record length decoding.
package cmd_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TYPE,
      LEN,
      ADDR_LO,
      ADDR_HI,
      DATA,
      SKIP,
      END
   } state_t;

   typedef enum logic [1:0] {
      KIND_LOAD,
      KIND_XFER,
      KIND_SKIP
   } kind_t;

   localparam logic [7:0] TYPE_EOF    = 8'h00;
   localparam logic [7:0] TYPE_LOAD   = 8'h01;
   localparam logic [7:0] TYPE_XFER   = 8'h02;
   localparam logic [7:0] TYPE_SKIP_A = 8'h05;
   localparam logic [7:0] TYPE_SKIP_B = 8'h1F;

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_TRUNC    = 2'b01;
   localparam logic [1:0] ST_NO_XFER  = 2'b10;
   localparam logic [1:0] ST_BAD_TYPE = 2'b11;

   // The length byte of a load record also covers the two address bytes,
   // so small values wrap around to the top of the 9-bit range.
   function automatic logic [8:0] load_count(input logic [7:0] len);
      return (len >= 8'd3) ? ({1'b0, len} - 9'd2) : ({1'b0, len} + 9'd254);
   endfunction

   function automatic logic [8:0] xfer_count(input logic [7:0] len);
      return (len >= 8'd2) ? ({1'b0, len} - 9'd2) : 9'd0;
   endfunction

   function automatic logic [8:0] skip_count(input logic [7:0] len);
      return (len == 8'd0) ? 9'd256 : {1'b0, len};
   endfunction

endpackage

// File: rtl/cmd_mem_port.sv
// Memory write side of the loader: one pending write, one skid entry,
// the auto-incrementing address counter and the registered stall request.
module cmd_mem_port
   import cmd_loader_pkg::*;
#(
   parameter int                 ADDR_W    = 16,
   parameter logic [ADDR_W-1:0]  LOAD_BASE = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              byte_vld,
   input  logic [7:0]        byte_data,
   input  logic              addr_load,
   input  logic [15:0]       addr_val,
   input  logic              flush,
   input  logic              mem_ready,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              ioctl_wait
);

   logic       hs;
   logic       skid_load;
   logic       skid_vld;
   logic [7:0] skid_data;

   assign hs = mem_wr && mem_ready;

   // A byte needs the skid entry whenever the write slot stays occupied
   // through this cycle: either not yet accepted, or refilled from the skid.
   assign skid_load = byte_vld && !flush && mem_wr && (!hs || skid_vld);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= 8'h00;
         ioctl_wait <= 1'b0;
         skid_vld   <= 1'b0;
      end else begin
         if (hs)
            mem_addr <= mem_addr + ADDR_W'(1);
         if (addr_load)
            mem_addr <= LOAD_BASE + ADDR_W'(addr_val);

         if (flush) begin
            skid_vld   <= 1'b0;
            if (hs)
               mem_wr <= 1'b0;
            ioctl_wait <= mem_wr && !hs;
         end else if (!mem_wr || hs) begin
            if (skid_vld) begin
               mem_data   <= skid_data;
               mem_wr     <= 1'b1;
               ioctl_wait <= 1'b1;
               skid_vld   <= skid_load;
            end else if (byte_vld) begin
               mem_data   <= byte_data;
               mem_wr     <= 1'b1;
               ioctl_wait <= 1'b1;
            end else begin
               mem_wr     <= 1'b0;
               ioctl_wait <= 1'b0;
            end
         end else begin
            if (skid_load)
               skid_vld <= 1'b1;
            ioctl_wait <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (skid_load)
         skid_data <= byte_data;
   end

endmodule

// File: rtl/cmd_stream_loader.sv
// /CMD record stream parser: decodes record headers from the ioctl byte
// stream and hands load-record payload bytes to the memory write port.
module cmd_stream_loader
   import cmd_loader_pkg::*;
#(
   parameter int                 ADDR_W    = 16,
   parameter logic [ADDR_W-1:0]  LOAD_BASE = '0,
   parameter logic [7:0]         MIN_INDEX = 8'd2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic              mem_wr,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              loader_download,
   output logic [15:0]       execute_addr,
   output logic              execute_enable,
   output logic [1:0]        status
);

   state_t     state;
   kind_t      kind;
   logic [8:0] cnt;
   logic [7:0] addr_lo;
   logic       dl_p1;

   logic       dl_rise;
   logic       byte_in;
   logic       byte_vld;
   logic       addr_load;
   logic       trunc;

   assign dl_rise   = ioctl_download && !dl_p1;
   assign byte_in   = ioctl_wr && ioctl_download;
   assign byte_vld  = byte_in && (state == DATA);
   assign addr_load = byte_in && (state == ADDR_HI) && (kind == KIND_LOAD);
   // Losing the download inside a record (anywhere but a record boundary)
   // means the file was cut short.
   assign trunc     = !ioctl_download &&
                      ((state == LEN) || (state == ADDR_LO) || (state == ADDR_HI) ||
                       (state == DATA) || (state == SKIP));

   cmd_mem_port #(
      .ADDR_W    (ADDR_W),
      .LOAD_BASE (LOAD_BASE)
   ) u_mem_port (
      .clock      (clock),
      .reset_n    (reset_n),
      .byte_vld   (byte_vld),
      .byte_data  (ioctl_dout),
      .addr_load  (addr_load),
      .addr_val   ({ioctl_dout, addr_lo}),
      .flush      (trunc),
      .mem_ready  (mem_ready),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .ioctl_wait (ioctl_wait)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         kind            <= KIND_LOAD;
         cnt             <= 9'd0;
         addr_lo         <= 8'h00;
         dl_p1           <= 1'b0;
         loader_download <= 1'b0;
         execute_addr    <= 16'h0000;
         execute_enable  <= 1'b0;
         status          <= ST_OK;
      end else begin
         dl_p1          <= ioctl_download;
         execute_enable <= 1'b0;

         if (trunc) begin
            status          <= ST_TRUNC;
            loader_download <= 1'b0;
            state           <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (dl_rise && (ioctl_index >= MIN_INDEX)) begin
                     loader_download <= 1'b1;
                     status          <= ST_OK;
                     state           <= TYPE;
                  end
               end
               TYPE: begin
                  if (!ioctl_download) begin
                     loader_download <= 1'b0;
                     state           <= IDLE;
                  end else if (ioctl_wr) begin
                     case (ioctl_dout)
                        TYPE_LOAD: begin
                           kind  <= KIND_LOAD;
                           state <= LEN;
                        end
                        TYPE_XFER: begin
                           kind  <= KIND_XFER;
                           state <= LEN;
                        end
                        TYPE_SKIP_A, TYPE_SKIP_B: begin
                           kind  <= KIND_SKIP;
                           state <= LEN;
                        end
                        TYPE_EOF: begin
                           status          <= ST_NO_XFER;
                           loader_download <= 1'b0;
                           state           <= END;
                        end
                        default: begin
                           status          <= ST_BAD_TYPE;
                           loader_download <= 1'b0;
                           state           <= END;
                        end
                     endcase
                  end
               end
               LEN: begin
                  if (ioctl_wr) begin
                     case (kind)
                        KIND_LOAD: begin
                           cnt   <= load_count(ioctl_dout);
                           state <= ADDR_LO;
                        end
                        KIND_XFER: begin
                           cnt   <= xfer_count(ioctl_dout);
                           state <= ADDR_LO;
                        end
                        default: begin
                           cnt   <= skip_count(ioctl_dout);
                           state <= SKIP;
                        end
                     endcase
                  end
               end
               ADDR_LO: begin
                  if (ioctl_wr) begin
                     addr_lo <= ioctl_dout;
                     state   <= ADDR_HI;
                  end
               end
               ADDR_HI: begin
                  if (ioctl_wr) begin
                     if (kind == KIND_LOAD) begin
                        state <= DATA;
                     end else begin
                        execute_addr   <= {ioctl_dout, addr_lo};
                        execute_enable <= 1'b1;
                        if (cnt != 9'd0) begin
                           state <= SKIP;
                        end else begin
                           loader_download <= 1'b0;
                           state           <= END;
                        end
                     end
                  end
               end
               DATA: begin
                  if (ioctl_wr) begin
                     cnt <= cnt - 9'd1;
                     if (cnt == 9'd1)
                        state <= TYPE;
                  end
               end
               SKIP: begin
                  if (ioctl_wr) begin
                     cnt <= cnt - 9'd1;
                     if (cnt == 9'd1) begin
                        if (kind == KIND_SKIP) begin
                           state <= TYPE;
                        end else begin
                           loader_download <= 1'b0;
                           state           <= END;
                        end
                     end
                  end
               end
               END: begin
                  if (!ioctl_download)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cmd_stream_loader.sv
// Directed bench for cmd_stream_loader: a 16-bit unrelocated instance and a
// 20-bit instance relocated to 0x10000 share one ioctl stream.
module tb_cmd_stream_loader;
   import cmd_loader_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'h00;
   logic        ioctl_wr = 1'b0;
   logic [7:0]  ioctl_dout = 8'h00;
   logic        mem_ready = 1'b1;

   logic        a_ioctl_wait, a_mem_wr, a_loader_download, a_execute_enable;
   logic [15:0] a_mem_addr, a_execute_addr;
   logic [7:0]  a_mem_data;
   logic [1:0]  a_status;
   logic        b_ioctl_wait, b_mem_wr, b_loader_download, b_execute_enable;
   logic [19:0] b_mem_addr;
   logic [15:0] b_execute_addr;
   logic [7:0]  b_mem_data;
   logic [1:0]  b_status;

   int checks = 0;
   int errors = 0;

   int          wa_n = 0, wb_n = 0, ea_n = 0;
   logic [23:0] wa_addr [0:2047];
   logic [7:0]  wa_data [0:2047];
   logic [23:0] wb_addr [0:2047];
   logic [7:0]  wb_data [0:2047];

   always #5 clock = ~clock;

   cmd_stream_loader #(.ADDR_W(16), .LOAD_BASE(16'h0000), .MIN_INDEX(8'd2)) dut_a (
      .clock(clock), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(a_ioctl_wait), .mem_wr(a_mem_wr), .mem_ready(mem_ready),
      .mem_addr(a_mem_addr), .mem_data(a_mem_data), .loader_download(a_loader_download),
      .execute_addr(a_execute_addr), .execute_enable(a_execute_enable), .status(a_status)
   );

   cmd_stream_loader #(.ADDR_W(20), .LOAD_BASE(20'h10000), .MIN_INDEX(8'd2)) dut_b (
      .clock(clock), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(b_ioctl_wait), .mem_wr(b_mem_wr), .mem_ready(mem_ready),
      .mem_addr(b_mem_addr), .mem_data(b_mem_data), .loader_download(b_loader_download),
      .execute_addr(b_execute_addr), .execute_enable(b_execute_enable), .status(b_status)
   );

   always @(posedge clock) begin
      if (a_mem_wr && mem_ready && wa_n < 2048) begin
         wa_addr[wa_n] <= {8'h00, a_mem_addr};
         wa_data[wa_n] <= a_mem_data;
         wa_n          <= wa_n + 1;
      end
      if (b_mem_wr && mem_ready && wb_n < 2048) begin
         wb_addr[wb_n] <= {4'h0, b_mem_addr};
         wb_data[wb_n] <= b_mem_data;
         wb_n          <= wb_n + 1;
      end
      if (a_execute_enable)
         ea_n <= ea_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      while (a_ioctl_wait && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $error("FAIL wait_timeout: observed ioctl_wait stuck 1 expected release within 100 cycles");
      end
      ioctl_wr   = 1'b1;
      ioctl_dout = b;
      @(negedge clock);
      ioctl_wr   = 1'b0;
   endtask

   task automatic start_dl(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      @(negedge clock);
   endtask

   task automatic end_dl();
      ioctl_download = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int e0;
      int bad;

      repeat (3) @(negedge clock);
      check("reset_ctrl", {27'd0, a_mem_wr, a_ioctl_wait, a_loader_download, a_execute_enable, a_status}, 32'd0);
      check("reset_addr", {a_mem_addr, a_execute_addr}, 32'd0);
      check("reset_b", {b_mem_wr, b_loader_download, b_status, b_mem_data}, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // Load record followed by a transfer record
      start_dl(8'd2);
      check("t1_dl_start", a_loader_download, 1);
      w0 = wa_n;
      e0 = ea_n;
      send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h80);
      ioctl_wr = 1'b1; ioctl_dout = 8'hAA;
      @(negedge clock);
      ioctl_wr = 1'b0;
      check("t1_issue", {7'd0, a_mem_wr, a_ioctl_wait, a_mem_data, a_mem_addr}, {7'd0, 1'b1, 1'b1, 8'hAA, 16'h8000});
      @(negedge clock);
      check("t1_done", {a_mem_wr, a_ioctl_wait}, 0);
      check("t1_count1", wa_n - w0, 1);
      send_byte(8'hBB); send_byte(8'hCC);
      send_byte(8'h02); send_byte(8'h02); send_byte(8'h00); send_byte(8'h80);
      check("t1_exec_pulse", {a_execute_enable, a_execute_addr}, {1'b1, 16'h8000});
      check("t1_dl_end", a_loader_download, 0);
      @(negedge clock);
      check("t1_exec_low", a_execute_enable, 0);
      check("t1_exec_count", ea_n - e0, 1);
      check("t1_status", a_status, ST_OK);
      check("t1_wcount", wa_n - w0, 3);
      check("t1_w0", {wa_addr[w0], wa_data[w0]}, {24'h008000, 8'hAA});
      check("t1_w1", {wa_addr[w0+1], wa_data[w0+1]}, {24'h008001, 8'hBB});
      check("t1_w2", {wa_addr[w0+2], wa_data[w0+2]}, {24'h008002, 8'hCC});
      check("t2_b_w0", {wb_addr[w0], wb_data[w0]}, {24'h018000, 8'hAA});
      check("t2_b_w2", {wb_addr[w0+2], wb_data[w0+2]}, {24'h018002, 8'hCC});
      check("t2_b_exec", b_execute_addr, 16'h8000);
      end_dl();

      // 256-byte record starting at the top of the 16-bit space
      start_dl(8'd2);
      w0 = wa_n;
      send_byte(8'h01); send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
      for (int i = 0; i < 256; i++)
         send_byte(8'(i));
      repeat (2) @(negedge clock);
      check("t3_wcount", wa_n - w0, 256);
      check("t3_first", {wa_addr[w0], wa_data[w0]}, {24'h00FFFF, 8'h00});
      check("t3_wrap", {wa_addr[w0+1], wa_data[w0+1]}, {24'h000000, 8'h01});
      check("t3_last", {wa_addr[w0+255], wa_data[w0+255]}, {24'h0000FE, 8'hFF});
      bad = 0;
      for (int i = 0; i < 256; i++)
         if (wa_addr[w0+i] !== 24'((16'hFFFF + i) & 16'hFFFF) || wa_data[w0+i] !== 8'(i))
            bad++;
      check("t3_all", bad, 0);
      check("t3_b_wrap", {wb_addr[w0+1], wb_data[w0+1]}, {24'h020000, 8'h01});
      send_byte(8'h00);
      check("t3_eof", {a_loader_download, a_status}, {1'b0, ST_NO_XFER});
      end_dl();

      // Two bytes back-to-back while RAM stalls
      start_dl(8'd2);
      w0 = wa_n;
      send_byte(8'h01); send_byte(8'h04); send_byte(8'h00); send_byte(8'h20);
      mem_ready  = 1'b0;
      ioctl_wr   = 1'b1; ioctl_dout = 8'h11;
      @(negedge clock);
      ioctl_dout = 8'h22;
      @(negedge clock);
      ioctl_wr   = 1'b0;
      repeat (3) @(negedge clock);
      check("t4_stall", {6'd0, a_ioctl_wait, a_mem_wr, a_mem_data, a_mem_addr}, {6'd0, 1'b1, 1'b1, 8'h11, 16'h2000});
      check("t4_nowrite", wa_n - w0, 0);
      mem_ready = 1'b1;
      @(negedge clock);
      check("t4_skid", {7'd0, a_ioctl_wait, a_mem_wr, a_mem_data, a_mem_addr}, {7'd0, 1'b1, 1'b1, 8'h22, 16'h2001});
      @(negedge clock);
      check("t4_drain", {a_ioctl_wait, a_mem_wr}, 0);
      check("t4_wcount", wa_n - w0, 2);
      check("t4_w0", {wa_addr[w0], wa_data[w0]}, {24'h002000, 8'h11});
      check("t4_w1", {wa_addr[w0+1], wa_data[w0+1]}, {24'h002001, 8'h22});
      send_byte(8'h07);
      check("t4_badtype", {a_loader_download, a_status}, {1'b0, ST_BAD_TYPE});
      end_dl();

      // Skip record then end-of-file
      start_dl(8'd2);
      check("t5_status_clr", a_status, ST_OK);
      w0 = wa_n;
      send_byte(8'h05); send_byte(8'h03); send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
      check("t5_after_skip", {a_loader_download, a_status}, {1'b1, ST_OK});
      send_byte(8'h00);
      check("t5_eof", {a_loader_download, a_status}, {1'b0, ST_NO_XFER});
      check("t5_nowrite", wa_n - w0, 0);
      end_dl();
      check("t5_status_hold", a_status, ST_NO_XFER);

      // Download dropped mid-DATA
      start_dl(8'd2);
      w0 = wa_n;
      send_byte(8'h01); send_byte(8'h0A); send_byte(8'h00); send_byte(8'h30);
      send_byte(8'hE1); send_byte(8'hE2);
      ioctl_download = 1'b0;
      @(negedge clock);
      check("t6_trunc", {a_loader_download, a_status}, {1'b0, ST_TRUNC});
      check("t6_idle", 32'(dut_a.state), 32'(IDLE));
      @(negedge clock);
      check("t6_wcount", wa_n - w0, 2);
      check("t6_w1", {wa_addr[w0+1], wa_data[w0+1]}, {24'h003001, 8'hE2});
      check("t6_b_trunc", b_status, ST_TRUNC);

      // Index below MIN_INDEX is ignored
      start_dl(8'd1);
      w0 = wa_n;
      send_byte(8'h01); send_byte(8'h03); send_byte(8'h00); send_byte(8'h40); send_byte(8'h55);
      repeat (2) @(negedge clock);
      check("t6_low_index", {a_loader_download, a_status}, {1'b0, ST_TRUNC});
      check("t6_low_nowrite", wa_n - w0, 0);
      end_dl();

      // Asynchronous reset with a write pending
      start_dl(8'd2);
      send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h50);
      mem_ready = 1'b0;
      w0 = wa_n;
      send_byte(8'h66);
      check("t7_pending", a_mem_wr, 1);
      #2 reset_n = 1'b0;
      #1;
      check("t7_async", {a_mem_wr, a_ioctl_wait, a_loader_download, a_mem_addr}, 0);
      mem_ready = 1'b1;
      repeat (2) @(negedge clock);
      check("t7_nowrite", wa_n - w0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
